// File: rtl/ls74_sched_pkg.sv
// ==== ls74_sched_pkg: shared types for the ls74 command scheduler. Rev 1.0 ====
`default_nettype none

package ls74_sched_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_CLEAR  = 2'b00,
    CMD_SET    = 2'b01,
    CMD_LOAD   = 2'b10,
    CMD_TOGGLE = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ASSERT  = 3'd1,
    ST_RELEASE = 3'd2,
    ST_CHECK   = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  // LOAD and TOGGLE go through the D/clock path rather than the async pins.
  function automatic logic is_clocked(input cmd_e c);
    return (c == CMD_LOAD) || (c == CMD_TOGGLE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ls74_cmd_sched_rr_arbiter.sv
// ==== rr_arbiter: first valid at or after ptr wins, one-hot grant plus index. Rev 1.0 ====
`default_nettype none

module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            j;
  logic [IW-1:0] jj;

  // Walk from the farthest offset down so the nearest valid is assigned last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |valid;
    j     = 0;
    jj    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j  = (int'(ptr) + k) % N;
      jj = IW'(j);
      if (valid[jj]) begin
        grant     = '0;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ls74_cmd_sched.sv
// ==== ls74_cmd_sched: round-robin scheduler driving a shared dual D flip-flop. Rev 1.0 ====
`default_nettype none

module ls74_cmd_sched
  import ls74_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int PULSE_W = 2,
  parameter int SETTLE  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_cmd,
  input  logic [NREQ-1:0]         req_ch,
  input  logic [NREQ-1:0]         req_d,
  output logic [NREQ-1:0]         req_ready,
  output logic                    n_pre1,
  output logic                    n_pre2,
  output logic                    n_clr1,
  output logic                    n_clr2,
  output logic                    ff_clk1,
  output logic                    ff_clk2,
  output logic                    d1,
  output logic                    d2,
  input  logic                    q1,
  input  logic                    q2,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_ok,
  output logic                    busy,
  output logic [7:0]              err_cnt
);

  localparam int IW      = $clog2(NREQ);
  localparam int CNT_MAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PW_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(SETTLE - 1);

  state_e        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr, id;
  cmd_e          cmd;
  logic          ch, exp_val, q_smp;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            gany, grant_en;
  cmd_e            g_cmd;
  logic            g_ch, g_exp, q_sel;

  rr_arbiter #(.N(NREQ)) u_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // No accept while rst is high: the edge that would capture it resets instead.
  assign grant_en  = (state == ST_IDLE) && gany && !rst;
  assign req_ready = grant_en ? grant : '0;
  assign q_sel     = ch ? q2 : q1;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    g_cmd = cmd_e'(req_cmd[int'(gidx)*CMD_W +: CMD_W]);
    g_ch  = req_ch[gidx];
    g_exp = 1'b0;
    case (g_cmd)
      CMD_CLEAR:  g_exp = 1'b0;
      CMD_SET:    g_exp = 1'b1;
      CMD_LOAD:   g_exp = req_d[gidx];
      CMD_TOGGLE: g_exp = ~(g_ch ? q2 : q1);
      default:    g_exp = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ptr     <= '0;
      id      <= '0;
      cmd     <= CMD_CLEAR;
      ch      <= 1'b0;
      exp_val <= 1'b0;
      q_smp   <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (grant_en) begin
            id      <= gidx;
            cmd     <= g_cmd;
            ch      <= g_ch;
            exp_val <= g_exp;
            cnt     <= PW_LAST;
            ptr     <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          end
        end
        ST_ASSERT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        ST_RELEASE: cnt <= ST_LAST;
        ST_CHECK: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           q_smp <= q_sel;
        end
        ST_RESP: begin
          if ((q_smp != exp_val) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (grant_en) state_nxt = ST_ASSERT;
      ST_ASSERT:  if (cnt == '0) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_CHECK;
      ST_CHECK:   if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  logic [1:0] pre_n, clr_n, fclk, dv;

  // Only one of preset/clear is ever pulled low, and only on the selected half.
  always_comb begin
    pre_n     = 2'b11;
    clr_n     = 2'b11;
    fclk      = 2'b00;
    dv        = 2'b00;
    rsp_valid = 1'b0;
    rsp_ok    = 1'b0;
    rsp_id    = '0;
    case (state)
      ST_ASSERT: begin
        case (cmd)
          CMD_CLEAR: clr_n[ch] = 1'b0;
          CMD_SET:   pre_n[ch] = 1'b0;
          default: begin
            dv[ch]   = exp_val;
            fclk[ch] = (cnt != PW_LAST);
          end
        endcase
      end
      ST_RELEASE: if (is_clocked(cmd)) dv[ch] = exp_val;
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id;
        rsp_ok    = (q_smp == exp_val);
      end
      default: ;
    endcase
  end

  assign n_pre1  = pre_n[0];
  assign n_pre2  = pre_n[1];
  assign n_clr1  = clr_n[0];
  assign n_clr2  = clr_n[1];
  assign ff_clk1 = fclk[0];
  assign ff_clk2 = fclk[1];
  assign d1      = dv[0];
  assign d2      = dv[1];

endmodule

`default_nettype wire
